// File: rtl/perf_csr.sv
// CSR front end for the performance monitor: start command, sticky status,
// counter shadows captured on measurement completion, and a level interrupt.
`timescale 1ns/1ps
module perf_csr #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter logic [31:0] ID_VALUE      = 32'h5045_5246
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     csr_req_valid,
    output logic                     csr_req_ready,
    input  logic                     csr_req_write,
    input  logic [5:0]               csr_req_addr,
    input  logic [31:0]              csr_req_wdata,
    output logic                     csr_rsp_valid,
    input  logic                     csr_rsp_ready,
    output logic [31:0]              csr_rsp_rdata,
    output logic                     csr_rsp_err,
    input  logic [COUNTER_WIDTH-1:0] total_cycles_in,
    input  logic [COUNTER_WIDTH-1:0] active_cycles_in,
    input  logic [COUNTER_WIDTH-1:0] idle_cycles_in,
    input  logic [31:0]              dma_bytes_in,
    input  logic [31:0]              blocks_in,
    input  logic [31:0]              stalls_in,
    input  logic                     measurement_done_in,
    output logic                     start_pulse,
    output logic                     irq
);

    // state | meaning
    // IDLE  | ready to accept a request
    // RESP  | response held until csr_rsp_ready
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        measuring_q, measuring_d;
    logic        overrun_q, overrun_d;
    logic        start_pulse_q, start_pulse_d;
    logic        irq_q, irq_d;
    logic [31:0] total_q, active_q, idle_q, dma_q, blocks_q, stalls_q;

    logic        accept;
    logic [3:0]  word;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        rd_only;
    logic        req_err;
    logic        ctrl_wr;
    logic        status_wr;
    logic        start_go;
    logic        unused_bits;

    assign word          = csr_req_addr[5:2];
    assign accept        = csr_req_valid && (state_q == ST_IDLE);
    assign csr_req_ready = (state_q == ST_IDLE);
    assign csr_rsp_valid = (state_q == ST_RESP);
    assign csr_rsp_rdata = rdata_q;
    assign csr_rsp_err   = err_q;
    assign start_pulse   = start_pulse_q;
    assign irq           = irq_q;
    assign unused_bits   = ^{csr_req_addr[1:0], csr_req_wdata[31:3]};

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        rd_only = 1'b1;
        case (word)
            4'd0: begin
                rd_data = {30'd0, irq_en_q, 1'b0};
                rd_only = 1'b0;
            end
            4'd1: begin
                rd_data = {29'd0, overrun_q, measuring_q, done_q};
                rd_only = 1'b0;
            end
            4'd2:    rd_data = total_q;
            4'd3:    rd_data = active_q;
            4'd4:    rd_data = idle_q;
            4'd5:    rd_data = dma_q;
            4'd6:    rd_data = blocks_q;
            4'd7:    rd_data = stalls_q;
            4'd8:    rd_data = ID_VALUE;
            default: rd_hit  = 1'b0;
        endcase
    end

    assign req_err   = !rd_hit || (csr_req_write && rd_only);
    assign ctrl_wr   = accept && csr_req_write && (word == 4'd0);
    assign status_wr = accept && csr_req_write && (word == 4'd1);
    assign start_go  = ctrl_wr && csr_req_wdata[0] && !measuring_q;

    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        measuring_d   = measuring_q;
        overrun_d     = overrun_q;
        start_pulse_d = start_go;
        irq_d         = irq_en_q && done_q;

        case (state_q)
            ST_IDLE: if (csr_req_valid) state_d = ST_RESP;
            ST_RESP: if (csr_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            err_d   = req_err;
            rdata_d = (req_err || csr_req_write) ? 32'd0 : rd_data;
        end

        if (ctrl_wr) irq_en_d = csr_req_wdata[1];

        // A done arriving alongside the start pulse belongs to the old run.
        if (measurement_done_in && !start_pulse_q) measuring_d = 1'b0;
        if (start_go) measuring_d = 1'b1;

        // Sets are applied after clears so a coincident set wins.
        if (status_wr && csr_req_wdata[0]) done_d = 1'b0;
        if (measurement_done_in) done_d = 1'b1;
        if (status_wr && csr_req_wdata[2]) overrun_d = 1'b0;
        if (measurement_done_in && done_q) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            measuring_q   <= 1'b0;
            overrun_q     <= 1'b0;
            start_pulse_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            measuring_q   <= measuring_d;
            overrun_q     <= overrun_d;
            start_pulse_q <= start_pulse_d;
            irq_q         <= irq_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q  <= '0;
            active_q <= '0;
            idle_q   <= '0;
            dma_q    <= '0;
            blocks_q <= '0;
            stalls_q <= '0;
        end else if (measurement_done_in) begin
            total_q  <= 32'(total_cycles_in);
            active_q <= 32'(active_cycles_in);
            idle_q   <= 32'(idle_cycles_in);
            dma_q    <= dma_bytes_in;
            blocks_q <= blocks_in;
            stalls_q <= stalls_in;
        end
    end

endmodule

// File: tb/tb_perf_csr.sv
// Scoreboard bench for perf_csr: directed CSR transactions queue expected
// responses, and a monitor compares them as responses are consumed.
`timescale 1ns/1ps
module tb_perf_csr;

    logic        clk;
    logic        rst;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic        csr_req_write;
    logic [5:0]  csr_req_addr;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_err;
    logic [31:0] total_cycles_in, active_cycles_in, idle_cycles_in;
    logic [31:0] dma_bytes_in, blocks_in, stalls_in;
    logic        measurement_done_in;
    logic        start_pulse;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    logic [32:0] exp_q[$];

    localparam logic [31:0] ID = 32'h5045_5246;

    perf_csr dut (
        .clk                 (clk),
        .rst                 (rst),
        .csr_req_valid       (csr_req_valid),
        .csr_req_ready       (csr_req_ready),
        .csr_req_write       (csr_req_write),
        .csr_req_addr        (csr_req_addr),
        .csr_req_wdata       (csr_req_wdata),
        .csr_rsp_valid       (csr_rsp_valid),
        .csr_rsp_ready       (csr_rsp_ready),
        .csr_rsp_rdata       (csr_rsp_rdata),
        .csr_rsp_err         (csr_rsp_err),
        .total_cycles_in     (total_cycles_in),
        .active_cycles_in    (active_cycles_in),
        .idle_cycles_in      (idle_cycles_in),
        .dma_bytes_in        (dma_bytes_in),
        .blocks_in           (blocks_in),
        .stalls_in           (stalls_in),
        .measurement_done_in (measurement_done_in),
        .start_pulse         (start_pulse),
        .irq                 (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every consumed response against the scoreboard.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst && csr_rsp_valid && csr_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got err=%b rdata=%h expected none",
                             csr_rsp_err, csr_rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", {31'd0, csr_rsp_err}, {31'd0, e[32]});
                    chk("rsp_rdata", csr_rsp_rdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (start_pulse) pulse_cnt++;
        end
    end

    task automatic set_counters(input logic [31:0] t, a, i, d, b, s);
        total_cycles_in  = t;
        active_cycles_in = a;
        idle_cycles_in   = i;
        dma_bytes_in     = d;
        blocks_in        = b;
        stalls_in        = s;
    endtask

    task automatic pulse_done(input logic [31:0] t, a, i, d, b, s);
        @(posedge clk); #1;
        set_counters(t, a, i, d, b, s);
        measurement_done_in = 1'b1;
        @(posedge clk); #1;
        measurement_done_in = 1'b0;
    endtask

    // dmode: 0 none, 1 done pulse on the acceptance edge, 2 on the edge after.
    task automatic txn(input bit wr, input logic [5:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit ee, input int dmode);
        int n;
        exp_q.push_back({ee, er});
        @(posedge clk); #1;
        csr_req_valid = 1'b1;
        csr_req_write = wr;
        csr_req_addr  = a;
        csr_req_wdata = wd;
        if (dmode == 1) measurement_done_in = 1'b1;
        n = 0;
        while (!csr_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        measurement_done_in = (dmode == 2);
        n = 0;
        while (csr_rsp_valid && n < 20) begin
            @(posedge clk); #1;
            measurement_done_in = 1'b0;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no completion expected completion within 20 cycles");
        end
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        csr_req_valid = 1'b0;
        csr_req_write = 1'b0;
        csr_req_addr  = '0;
        csr_req_wdata = '0;
        csr_rsp_ready = 1'b1;
        measurement_done_in = 1'b0;
        set_counters(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, csr_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, csr_rsp_valid}, 32'd0);
        chk("rst_start_pulse", {31'd0, start_pulse}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        txn(0, 6'h04, 0, 32'h0, 0, 0);
        txn(0, 6'h08, 0, 32'h0, 0, 0);
        txn(0, 6'h20, 0, ID, 0, 0);

        txn(1, 6'h00, 32'h3, 32'h0, 0, 0);
        chk("start_pulse_once", pulse_cnt, 1);
        txn(0, 6'h04, 0, 32'h2, 0, 0);
        txn(0, 6'h00, 0, 32'h2, 0, 0);
        txn(1, 6'h00, 32'h3, 32'h0, 0, 0);
        chk("start_ignored", pulse_cnt, 1);

        pulse_done(100, 80, 20, 4096, 16, 7);
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_set", {31'd0, irq}, 32'd1);
        txn(0, 6'h04, 0, 32'h1, 0, 0);
        txn(0, 6'h08, 0, 32'd100, 0, 0);
        txn(0, 6'h0C, 0, 32'd80, 0, 0);
        txn(0, 6'h10, 0, 32'd20, 0, 0);
        txn(0, 6'h14, 0, 32'd4096, 0, 0);
        txn(0, 6'h18, 0, 32'd16, 0, 0);
        txn(0, 6'h1C, 0, 32'd7, 0, 0);

        pulse_done(200, 150, 50, 8192, 32, 9);
        txn(0, 6'h04, 0, 32'h5, 0, 0);
        txn(0, 6'h08, 0, 32'd200, 0, 0);
        txn(0, 6'h1C, 0, 32'd9, 0, 0);
        txn(1, 6'h04, 32'h5, 32'h0, 0, 0);
        txn(0, 6'h04, 0, 32'h0, 0, 0);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        pulse_done(1, 2, 3, 4, 5, 6);
        set_counters(11, 12, 13, 14, 15, 16);
        txn(1, 6'h04, 32'h1, 32'h0, 0, 1);
        txn(0, 6'h04, 0, 32'h5, 0, 0);
        txn(0, 6'h08, 0, 32'd11, 0, 0);
        txn(1, 6'h04, 32'h5, 32'h0, 0, 0);

        txn(0, 6'h24, 0, 32'h0, 1, 0);
        txn(1, 6'h08, 32'hDEAD_BEEF, 32'h0, 1, 0);
        txn(0, 6'h08, 0, 32'd11, 0, 0);
        txn(1, 6'h20, 32'h1234, 32'h0, 1, 0);

        // Response back-pressure: fields must hold while not consumed.
        csr_rsp_ready = 1'b0;
        exp_q.push_back({1'b0, ID});
        @(posedge clk); #1;
        csr_req_valid = 1'b1;
        csr_req_write = 1'b0;
        csr_req_addr  = 6'h20;
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        held = csr_rsp_rdata;
        for (int k = 0; k < 5; k++) begin
            chk("stall_rsp_valid", {31'd0, csr_rsp_valid}, 32'd1);
            chk("stall_req_ready", {31'd0, csr_req_ready}, 32'd0);
            chk("stall_rdata", csr_rsp_rdata, ID);
            chk("stall_rdata_hold", csr_rsp_rdata, held);
            @(posedge clk); #1;
        end
        csr_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_released", {31'd0, csr_rsp_valid}, 32'd0);

        // Done coincident with the start pulse: capture happens, MEASURING stays.
        set_counters(31, 32, 33, 34, 35, 36);
        txn(1, 6'h00, 32'h1, 32'h0, 0, 2);
        chk("start_pulse_second", pulse_cnt, 2);
        txn(0, 6'h04, 0, 32'h3, 0, 0);
        txn(0, 6'h08, 0, 32'd31, 0, 0);
        chk("irq_disabled", {31'd0, irq}, 32'd0);

        // Reset in the middle of a pending response.
        csr_rsp_ready = 1'b0;
        @(posedge clk); #1;
        csr_req_valid = 1'b1;
        csr_req_write = 1'b0;
        csr_req_addr  = 6'h20;
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        chk("pre_rst_rsp_valid", {31'd0, csr_rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", {31'd0, csr_rsp_valid}, 32'd0);
        chk("async_rst_req_ready", {31'd0, csr_req_ready}, 32'd1);
        chk("async_rst_rdata", csr_rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        csr_rsp_ready = 1'b1;
        txn(0, 6'h00, 0, 32'h0, 0, 0);
        txn(0, 6'h04, 0, 32'h0, 0, 0);
        txn(0, 6'h08, 0, 32'h0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perf_csr.md
PERF_CSR -- requirements
Module: perf_csr

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, the width of the cycle-counter inputs; legal range 1..32.
REQ-002 SHALL have parameter ID_VALUE, default 32'h5045_5246, the constant returned at the ID register.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 csr_req_valid  input  1  request present.
REQ-006 csr_req_ready  output  1  request accepted when high with csr_req_valid.
REQ-007 csr_req_write  input  1  1 = write, 0 = read.
REQ-008 csr_req_addr  input  6  byte address; bits [1:0] ignored.
REQ-009 csr_req_wdata  input  32  write data.
REQ-010 csr_rsp_valid  output  1  response present.
REQ-011 csr_rsp_ready  input  1  response consumed when high with csr_rsp_valid.
REQ-012 csr_rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 csr_rsp_err  output  1  unmapped address, or a write to a read-only register.
REQ-014 total_cycles_in, active_cycles_in, idle_cycles_in  input  COUNTER_WIDTH each  counter results from the performance monitor.
REQ-015 dma_bytes_in, blocks_in, stalls_in  input  32 each  counter results from the performance monitor.
REQ-016 measurement_done_in  input  1  one-cycle pulse; the counter inputs are valid in the same cycle.
REQ-017 start_pulse  output  1  one-cycle start command to the performance monitor.
REQ-018 irq  output  1  level interrupt.

Function
REQ-019 Register map (word offsets):
- 0x00 CTRL: bit0 START (write 1 to pulse, reads 0); bit1 IRQ_EN (read/write).
- 0x04 STATUS: bit0 DONE (sticky, write 1 to clear); bit1 MEASURING (read-only); bit2 OVERRUN (sticky, write 1 to clear).
- 0x08 TOTAL, 0x0C ACTIVE, 0x10 IDLE, 0x14 DMA_BYTES, 0x18 BLOCKS, 0x1C STALLS: read-only shadow registers.
- 0x20 ID: read-only.
- All other offsets: error.
REQ-020 Handshake FSM has two states, IDLE and RESP; csr_req_ready = (state == IDLE).
REQ-021 IDLE -> RESP on csr_req_valid; write side effects commit on the acceptance edge; response fields are registered and valid in the next cycle.
REQ-022 RESP -> IDLE on csr_rsp_ready; rdata and err SHALL stay stable while csr_rsp_valid && !csr_rsp_ready; one transaction outstanding at most.
REQ-023 Writes of 1 to CTRL.START while MEASURING = 0: start_pulse high for exactly the cycle after acceptance, and MEASURING set in that same cycle.
REQ-024 Writes of 1 to CTRL.START while MEASURING = 1: ignored, no pulse, err = 0.
REQ-025 On measurement_done_in, all six shadow registers capture their inputs, zero-extended to 32 bits, on that clock edge.
REQ-026 On measurement_done_in, DONE is set and MEASURING is cleared.
REQ-027 measurement_done_in while DONE = 1: OVERRUN set, shadows still overwritten.
REQ-028 A W1C clear and a set of the same STATUS bit in the same cycle: set wins.
REQ-029 measurement_done_in in the same cycle as start_pulse: MEASURING ends at 1, and the capture still occurs.
REQ-030 measurement_done_in while MEASURING = 0: capture and DONE set still occur (the monitor may be started externally).
REQ-031 irq = IRQ_EN & DONE, registered; asserts in the cycle after DONE becomes 1 with IRQ_EN = 1.
REQ-032 Reads have no side effects; unused register bits read 0.
REQ-033 A write to a read-only register returns err = 1 and changes no state; error responses carry rdata = 0.

Reset
REQ-034 While rst is high, and asynchronously on assertion: FSM = IDLE, csr_req_ready = 1, csr_rsp_valid = 0, rdata = 0, err = 0, start_pulse = 0, irq = 0.
REQ-035 While rst is high: CTRL, STATUS and all shadow registers = 0.
REQ-036 Reset asserted mid-transaction drops the pending response; the first cycle after release accepts a new request.

Verification
REQ-037 Reset -> read 0x04 and 0x08 return 0; read 0x20 returns 32'h5045_5246 with err = 0.
REQ-038 Write 0x00 = 0x3 -> start_pulse high for one cycle and STATUS reads 0x2; a second START write gives no pulse.
REQ-039 measurement_done_in with total = 100, active = 80, idle = 20, dma_bytes = 4096, blocks = 16, stalls = 7 -> the shadows read back those values, STATUS = 0x1, irq = 1 one cycle later.
REQ-040 A second done pulse before clearing -> STATUS = 0x5 and the shadows hold the new values; write 0x04 = 0x5 -> STATUS = 0x0, irq = 0.
REQ-041 W1C of DONE in the same cycle as measurement_done_in -> DONE remains 1.
REQ-042 Read 0x24 -> err = 1, rdata = 0; write to 0x08 -> err = 1 and the shadow is unchanged.
REQ-043 csr_rsp_ready held low for 5 cycles -> csr_rsp_valid and rdata stable and csr_req_ready = 0 throughout.
